// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer sharing one synchronous memory port
// between the multicycle CPU and a secondary (DMA / loader) requester.
module mem_port_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       grant;
  logic       grant_dma;
  logic       last_beat;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_dma = 1'b0;
    last_beat = (state == WAIT) && (cnt == 4'd1);
    case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          grant = 1'b1;
          // On a tie the requester that did not go last wins.
          grant_dma = (cpu_req && dma_req) ? ~owner : dma_req;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= 1'b1;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      mem_en   <= (state_nxt == ISSUE);
      cpu_done <= last_beat && !owner;
      dma_done <= last_beat && owner;
      if (grant) begin
        owner     <= grant_dma;
        mem_we    <= grant_dma ? dma_we    : cpu_we;
        mem_addr  <= grant_dma ? dma_addr  : cpu_addr;
        mem_wdata <= grant_dma ? dma_wdata : cpu_wdata;
      end
      if (state == ISSUE) begin
        cnt <= LAT_CNT;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      // The last WAIT cycle is the one in which the memory presents read data.
      if (last_beat && !mem_we) begin
        if (owner) dma_rdata <= mem_rdata;
        else       cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level reference model
// predicts grants, strobes, done pulses and read data cycle by cycle.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          cpu_req, cpu_we, cpu_done;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_done;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          mem_en, mem_we, busy, owner;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_done  (dma_done),
    .dma_rdata (dma_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents as a pure function of address.
  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // Memory slave: read data is valid only in the cycle LAT after the strobe.
  int            tgt = -100;
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (mem_en && !mem_we) begin
      tgt  <= cyc + LAT;
      rd_q <= mem_val(mem_addr);
    end
    if (mem_en && !mem_we && LAT == 1) mem_rdata <= mem_val(mem_addr);
    else if (tgt == cyc + 1)           mem_rdata <= rd_q;
    else                               mem_rdata <= $urandom;
  end

  // Reference model state: one transaction at a time, timed from its grant.
  logic          own_m = 1'b1;
  logic          g_m = 1'b0, we_m = 1'b0;
  logic [AW-1:0] addr_m = '0;
  logic [DW-1:0] wd_m = '0, exp_cpu_rd = '0, exp_dma_rd = '0;
  int            idle_at = 0, issue_c = -1, done_c = -1;
  int            n_cpu_done = 0, n_dma_done = 0;
  logic          cpu_done_seen = 1'b0, dma_done_seen = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_cpu_done", cpu_done, 0);
        check_eq("rst_dma_done", dma_done, 0);
        check_eq("rst_cpu_rdata", cpu_rdata, 0);
        check_eq("rst_dma_rdata", dma_rdata, 0);
        check_eq("rst_owner", owner, 1);
        own_m = 1'b1; idle_at = 0; issue_c = -1; done_c = -1;
        exp_cpu_rd = '0; exp_dma_rd = '0;
        cpu_done_seen = 1'b0; dma_done_seen = 1'b0;
      end else begin
        if (cyc == done_c && !we_m) begin
          if (g_m) exp_dma_rd = mem_val(addr_m);
          else     exp_cpu_rd = mem_val(addr_m);
        end
        check_eq("mem_en", mem_en, cyc == issue_c);
        check_eq("busy", busy, cyc >= issue_c && cyc <= done_c);
        check_eq("cpu_done", cpu_done, cyc == done_c && !g_m);
        check_eq("dma_done", dma_done, cyc == done_c && g_m);
        check_eq("owner", owner, own_m);
        check_eq("cpu_rdata", cpu_rdata, exp_cpu_rd);
        check_eq("dma_rdata", dma_rdata, exp_dma_rd);
        if (cyc >= issue_c && cyc <= done_c) begin
          check_eq("mem_we", mem_we, we_m);
          check_eq("mem_addr", mem_addr, addr_m);
          check_eq("mem_wdata", mem_wdata, wd_m);
        end
        if (cpu_done) n_cpu_done++;
        if (dma_done) n_dma_done++;
        cpu_done_seen = cpu_done;
        dma_done_seen = dma_done;
        if (cyc >= idle_at && (cpu_req || dma_req)) begin
          g_m     = (cpu_req && dma_req) ? !own_m : dma_req;
          own_m   = g_m;
          we_m    = g_m ? dma_we    : cpu_we;
          addr_m  = g_m ? dma_addr  : cpu_addr;
          wd_m    = g_m ? dma_wdata : cpu_wdata;
          issue_c = cyc + 1;
          done_c  = cyc + LAT + 2;
          idle_at = cyc + LAT + 3;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic new_cpu();
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 32'($urandom_range(0, 255)) << 2;
    cpu_wdata = $urandom;
  endtask

  task automatic new_dma();
    dma_we    = 1'($urandom_range(0, 1));
    dma_addr  = 32'($urandom_range(0, 255)) << 2;
    dma_wdata = $urandom;
  endtask

  // Requesters hold req until done, then drop it or present a new command;
  // pending commands are occasionally changed to exercise the grant latch.
  task automatic drive_random();
    if (cpu_req) begin
      if (cpu_done_seen) begin
        if ($urandom_range(0, 3) == 0) cpu_req = 1'b0;
        else new_cpu();
      end else if ($urandom_range(0, 3) == 0) new_cpu();
    end else if ($urandom_range(0, 2) == 0) begin
      cpu_req = 1'b1;
      new_cpu();
    end
    if (dma_req) begin
      if (dma_done_seen) begin
        if ($urandom_range(0, 3) == 0) dma_req = 1'b0;
        else new_dma();
      end else if ($urandom_range(0, 3) == 0) new_dma();
    end else if ($urandom_range(0, 2) == 0) begin
      dma_req = 1'b1;
      new_dma();
    end
  endtask

  int c0, d0;

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    // Single CPU read of 0x40; the address input changes after the grant.
    cpu_we = 0; cpu_addr = 32'h40; cpu_req = 1;
    step(1);
    cpu_addr = 32'h44;
    step(LAT + 2);
    cpu_req = 0;
    check_eq("single_rdata", cpu_rdata, 32'hDEADBEEF);
    check_eq("single_owner", owner, 0);
    check_eq("single_dma_idle", n_dma_done, 0);
    check_eq("single_cpu_cnt", n_cpu_done, 1);
    step(2);

    // Tie right after reset, both held for four transactions.
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    c0 = n_cpu_done; d0 = n_dma_done;
    cpu_we = 0; cpu_addr = 32'h100; cpu_req = 1;
    dma_we = 0; dma_addr = 32'h200; dma_req = 1;
    step(4 * (LAT + 3));
    cpu_req = 0; dma_req = 0;
    check_eq("rr_cpu_cnt", n_cpu_done - c0, 2);
    check_eq("rr_dma_cnt", n_dma_done - d0, 2);
    check_eq("rr_owner", owner, 1);
    check_eq("rr_dma_rdata", dma_rdata, mem_val(32'h200));
    check_eq("rr_cpu_rdata", cpu_rdata, mem_val(32'h100));
    step(1);

    // DMA write leaves dma_rdata untouched.
    d0 = n_dma_done;
    dma_we = 1; dma_addr = 32'h80; dma_wdata = 32'h1234; dma_req = 1;
    step(LAT + 3);
    dma_req = 0; dma_we = 0;
    check_eq("wr_done_cnt", n_dma_done - d0, 1);
    check_eq("wr_rdata_held", dma_rdata, mem_val(32'h200));
    step(2);

    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step(1);
    end
    cpu_req = 0; dma_req = 0;
    step(LAT + 4);

    // Reset while a CPU read sits in WAIT.
    cpu_we = 0; cpu_addr = 32'h40; cpu_req = 1;
    step(2);
    c0 = n_cpu_done;
    rst_n = 1'b0;
    #1;
    check_eq("rstw_busy", busy, 0);
    check_eq("rstw_owner", owner, 1);
    check_eq("rstw_mem_addr", mem_addr, 0);
    check_eq("rstw_cpu_rdata", cpu_rdata, 0);
    cpu_req = 0;
    step(2);
    rst_n = 1'b1;
    step(LAT + 4);
    check_eq("rstw_no_done", n_cpu_done - c0, 0);
    cpu_req = 1;
    step(LAT + 3);
    cpu_req = 0;
    check_eq("rstw_after_cnt", n_cpu_done - c0, 1);
    check_eq("rstw_after_rdata", cpu_rdata, 32'hDEADBEEF);
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
